// File: rtl/oc2_pkg.sv
// Shared execute-stage definitions: register address width, functional-unit
// codes and the multiplier pipeline slot record.
package oc2_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PROD_W     = 64;

  localparam logic [1:0] FU_ALUMISC = 2'b00;
  localparam logic [1:0] FU_MEM     = 2'b01;
  localparam logic [1:0] FU_MUL     = 2'b10;
  localparam logic [1:0] FU_NONE    = 2'b11;

  // Slot 0 keeps the raw operands {a, b} in the product field; later slots
  // hold the finished product.
  typedef struct packed {
    logic                  valid;
    logic                  unsig;
    logic [REG_ADDR_W-1:0] regdest;
    logic                  writereg;
    logic [PROD_W-1:0]     product;
  } mul_slot_t;

endpackage

// File: rtl/mul_slot_reg.sv
// One multiplier pipeline slot: loads on advance, cleared by synchronous reset.
module mul_slot_reg
  import oc2_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      advance,
  input  mul_slot_t d,
  output mul_slot_t q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (advance) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Fixed-latency multiplier functional unit with writeback handshake and
// scoreboard clear. Define MUL_SIGNED_EN to honour iss_mul_unsig per operation.
module mul_unit
  import oc2_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iss_mul_oper,
  input  logic [DATA_W-1:0]     iss_mul_rega,
  input  logic [DATA_W-1:0]     iss_mul_regb,
  input  logic                  iss_mul_unsig,
  input  logic [REG_ADDR_W-1:0] iss_mul_regdest,
  input  logic                  iss_mul_writereg,
  output logic                  mul_iss_ready,
  output logic                  mul_wb_valid,
  output logic [DATA_W-1:0]     mul_wb_lo,
  output logic [DATA_W-1:0]     mul_wb_hi,
  output logic [REG_ADDR_W-1:0] mul_wb_regdest,
  output logic                  mul_wb_writereg,
  input  logic                  wb_mul_ready,
  output logic                  mul_sb_clear,
  output logic [REG_ADDR_W-1:0] mul_sb_addr,
  output logic                  mul_busy
);

  localparam int P = 2 * DATA_W;

  // Handshakes: issue transfers on a rising edge where iss_mul_oper and
  // mul_iss_ready are both high; writeback transfers where mul_wb_valid and
  // wb_mul_ready are both high. Payloads are held while the partner is not ready.

  mul_slot_t slot_q [LATENCY];
  mul_slot_t slot_d [LATENCY];

  logic              stall;
  logic              advance;
  logic              wb_fire;
  logic              unsig_in;
  logic              signed_mode;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [P-1:0]      op_a_ext;
  logic [P-1:0]      op_b_ext;
  logic [P-1:0]      full_prod;

  assign stall         = slot_q[LATENCY-1].valid & ~wb_mul_ready;
  assign advance       = ~stall;
  assign mul_iss_ready = advance;

`ifdef MUL_SIGNED_EN
  assign unsig_in    = iss_mul_unsig;
  assign signed_mode = ~slot_q[0].unsig;
`else
  // Every multiply is unsigned, so the mode bit is a constant and folds away.
  assign unsig_in    = iss_mul_unsig | 1'b1;
  assign signed_mode = 1'b0;
`endif

  assign op_a     = slot_q[0].product[P-1:DATA_W];
  assign op_b     = slot_q[0].product[DATA_W-1:0];
  assign op_a_ext = signed_mode ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
  assign op_b_ext = signed_mode ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
  assign full_prod = op_a_ext * op_b_ext;

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      slot_d[i] = '0;
    end
    slot_d[0].valid           = iss_mul_oper & advance;
    slot_d[0].unsig           = unsig_in;
    slot_d[0].regdest         = iss_mul_regdest;
    slot_d[0].writereg        = iss_mul_writereg;
    slot_d[0].product[P-1:0]  = {iss_mul_rega, iss_mul_regb};
    // The multiply happens on the s[0] -> s[1] transfer.
    slot_d[1]                 = slot_q[0];
    slot_d[1].product         = '0;
    slot_d[1].product[P-1:0]  = full_prod;
    for (int i = 2; i < LATENCY; i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  for (genvar g = 0; g < LATENCY; g++) begin : g_slot
    mul_slot_reg u_slot (
      .clock   (clock),
      .reset   (reset),
      .advance (advance),
      .d       (slot_d[g]),
      .q       (slot_q[g])
    );
  end

  assign wb_fire         = slot_q[LATENCY-1].valid & wb_mul_ready;
  assign mul_wb_valid    = slot_q[LATENCY-1].valid;
  assign mul_wb_lo       = slot_q[LATENCY-1].valid ? slot_q[LATENCY-1].product[DATA_W-1:0] : '0;
  assign mul_wb_hi       = slot_q[LATENCY-1].valid ? slot_q[LATENCY-1].product[P-1:DATA_W] : '0;
  assign mul_wb_regdest  = slot_q[LATENCY-1].valid ? slot_q[LATENCY-1].regdest : '0;
  assign mul_wb_writereg = slot_q[LATENCY-1].valid & slot_q[LATENCY-1].writereg
                         & (slot_q[LATENCY-1].regdest != '0);
  // Register 0 still gets its clear so issue never waits on it.
  assign mul_sb_clear    = wb_fire & slot_q[LATENCY-1].writereg;
  assign mul_sb_addr     = wb_fire ? slot_q[LATENCY-1].regdest : '0;

  always_comb begin
    mul_busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      mul_busy = mul_busy | slot_q[i].valid;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: directed multiplies with hand-computed
// products, back-to-back issue, writeback backpressure and mid-flight reset.
module tb_mul_unit;

  localparam int LATENCY = 4;
  localparam int DATA_W  = 32;
  localparam int EW      = 87; // {exact, issue_cyc[16], rd[5], wr, prod[64]}

  logic              clock;
  logic              reset;
  logic              iss_mul_oper;
  logic [DATA_W-1:0] iss_mul_rega;
  logic [DATA_W-1:0] iss_mul_regb;
  logic              iss_mul_unsig;
  logic [4:0]        iss_mul_regdest;
  logic              iss_mul_writereg;
  logic              mul_iss_ready;
  logic              mul_wb_valid;
  logic [DATA_W-1:0] mul_wb_lo;
  logic [DATA_W-1:0] mul_wb_hi;
  logic [4:0]        mul_wb_regdest;
  logic              mul_wb_writereg;
  logic              wb_mul_ready;
  logic              mul_sb_clear;
  logic [4:0]        mul_sb_addr;
  logic              mul_busy;

  mul_unit #(.LATENCY(LATENCY), .DATA_W(DATA_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .iss_mul_oper     (iss_mul_oper),
    .iss_mul_rega     (iss_mul_rega),
    .iss_mul_regb     (iss_mul_regb),
    .iss_mul_unsig    (iss_mul_unsig),
    .iss_mul_regdest  (iss_mul_regdest),
    .iss_mul_writereg (iss_mul_writereg),
    .mul_iss_ready    (mul_iss_ready),
    .mul_wb_valid     (mul_wb_valid),
    .mul_wb_lo        (mul_wb_lo),
    .mul_wb_hi        (mul_wb_hi),
    .mul_wb_regdest   (mul_wb_regdest),
    .mul_wb_writereg  (mul_wb_writereg),
    .wb_mul_ready     (wb_mul_ready),
    .mul_sb_clear     (mul_sb_clear),
    .mul_sb_addr      (mul_sb_addr),
    .mul_busy         (mul_busy)
  );

  // clock / reset / cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            passed;
  int            total;
  bit            mon_en;

  logic [31:0] a_t [6];
  logic [31:0] b_t [6];
  logic [63:0] p_t [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // driver: present one op, hold until accepted, record expectation
  task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic unsig,
                          input logic [4:0] rd, input logic wr, input logic [63:0] prod,
                          input logic exact);
    bit ok;
    ok               = 1'b0;
    iss_mul_oper     = 1'b1;
    iss_mul_rega     = a;
    iss_mul_regb     = b;
    iss_mul_unsig    = unsig;
    iss_mul_regdest  = rd;
    iss_mul_writereg = wr;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (mul_iss_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 64'd1, 64'd0);
    else exp_q.push_back({exact, 16'(cyc), rd, wr, prod});
    @(posedge clock);
    #1;
    iss_mul_oper = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !mul_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'd1, 64'd0);
    @(posedge clock);
    #1;
  endtask

  // monitor: compare every accepted writeback against the queue head
  always @(negedge clock) begin
    if (!reset && mon_en) begin
      if (mul_wb_valid && wb_mul_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_lo", 64'(mul_wb_lo), 64'(mon_e[31:0]));
          chk("wb_hi", 64'(mul_wb_hi), 64'(mon_e[63:32]));
          chk("wb_regdest", 64'(mul_wb_regdest), 64'(mon_e[69:65]));
          chk("wb_writereg", 64'(mul_wb_writereg), 64'(mon_e[64] && (mon_e[69:65] != 5'd0)));
          chk("sb_clear", 64'(mul_sb_clear), 64'(mon_e[64]));
          chk("sb_addr", 64'(mul_sb_addr), 64'(mon_e[69:65]));
          if (mon_e[86]) chk("latency", 64'(cyc - int'(mon_e[85:70])), 64'(LATENCY));
        end
      end else begin
        chk("sb_clear_idle", 64'(mul_sb_clear), 64'd0);
      end
    end
  end

  initial begin
    passed = 0;
    total  = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    iss_mul_oper = 1'b0;
    iss_mul_rega = '0;
    iss_mul_regb = '0;
    iss_mul_unsig = 1'b1;
    iss_mul_regdest = '0;
    iss_mul_writereg = 1'b0;
    wb_mul_ready = 1'b1;

    a_t[0] = 32'h0001_0000; b_t[0] = 32'h0001_0000; p_t[0] = 64'h0000_0001_0000_0000;
    a_t[1] = 32'hFFFF_FFFF; b_t[1] = 32'hFFFF_FFFF; p_t[1] = 64'hFFFF_FFFE_0000_0001;
    a_t[2] = 32'h1234_5678; b_t[2] = 32'h0000_0010; p_t[2] = 64'h0000_0001_2345_6780;
    a_t[3] = 32'h8000_0000; b_t[3] = 32'h8000_0000; p_t[3] = 64'h4000_0000_0000_0000;
    a_t[4] = 32'h0000_0000; b_t[4] = 32'hDEAD_BEEF; p_t[4] = 64'h0;
    a_t[5] = 32'h0000_FFFF; b_t[5] = 32'h0000_FFFF; p_t[5] = 64'h0000_0000_FFFE_0001;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_wb_valid", 64'(mul_wb_valid), 64'd0);
    chk("rst_wb_lo", 64'(mul_wb_lo), 64'd0);
    chk("rst_wb_hi", 64'(mul_wb_hi), 64'd0);
    chk("rst_sb_clear", 64'(mul_sb_clear), 64'd0);
    chk("rst_busy", 64'(mul_busy), 64'd0);
    chk("rst_iss_ready", 64'(mul_iss_ready), 64'd1);
    mon_en = 1'b1;
    @(posedge clock);
    #1;

    // single unsigned op: 3 * 7 -> 0x15, result LATENCY cycles later
    issue_op(32'd3, 32'd7, 1'b1, 5'd5, 1'b1, 64'h15, 1'b1);
    wait_idle();

    // signed vs unsigned interpretation
    issue_op(32'hFFFF_FFFF, 32'd2, 1'b1, 5'd7, 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b1);
`ifdef MUL_SIGNED_EN
    issue_op(32'hFFFF_FFFF, 32'd2, 1'b0, 5'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    issue_op(32'hFFFF_FFFD, 32'd5, 1'b0, 5'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
`else
    issue_op(32'hFFFF_FFFF, 32'd2, 1'b0, 5'd8, 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b1);
    issue_op(32'hFFFF_FFFD, 32'd5, 1'b0, 5'd9, 1'b1, 64'h0000_0004_FFFF_FFF1, 1'b1);
`endif
    wait_idle();

    // back-to-back, one per cycle
    for (int i = 0; i < 6; i++) issue_op(a_t[i], b_t[i], 1'b1, 5'(i + 1), 1'b1, p_t[i], 1'b1);
    wait_idle();

    // backpressure with a full pipe: writeback stalls for four cycles
    fork
      begin
        for (int i = 0; i < 6; i++) issue_op(a_t[i], b_t[i], 1'b1, 5'(i + 11), 1'b1, p_t[i], 1'b0);
      end
      begin
        repeat (4) @(posedge clock);
        #1 wb_mul_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          chk("stall_iss_ready", 64'(mul_iss_ready), 64'd0);
          chk("stall_wb_valid", 64'(mul_wb_valid), 64'd1);
          chk("stall_wb_lo", 64'(mul_wb_lo), 64'(p_t[0][31:0]));
          chk("stall_wb_hi", 64'(mul_wb_hi), 64'(p_t[0][63:32]));
          chk("stall_wb_regdest", 64'(mul_wb_regdest), 64'd11);
          chk("stall_busy", 64'(mul_busy), 64'd1);
        end
        @(posedge clock);
        #1 wb_mul_ready = 1'b1;
      end
    join
    wait_idle();

    // regdest 0 still clears the scoreboard but never writes; writereg=0 never clears
    issue_op(32'd6, 32'd7, 1'b1, 5'd0, 1'b1, 64'h2A, 1'b1);
    issue_op(32'd2, 32'd3, 1'b1, 5'd10, 1'b0, 64'h6, 1'b1);
    wait_idle();

    // reset with two ops in flight
    issue_op(32'd100, 32'd100, 1'b1, 5'd20, 1'b1, 64'd10000, 1'b0);
    issue_op(32'd5, 32'd5, 1'b1, 5'd21, 1'b1, 64'd25, 1'b0);
    chk("inflight_busy", 64'(mul_busy), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("flush_wb_valid", 64'(mul_wb_valid), 64'd0);
    chk("flush_busy", 64'(mul_busy), 64'd0);
    chk("flush_iss_ready", 64'(mul_iss_ready), 64'd1);
    chk("flush_sb_clear", 64'(mul_sb_clear), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("flush_no_wb", 64'(mul_wb_valid), 64'd0);
    end
    @(posedge clock);
    #1;

    // unit recovers after the flush
    issue_op(32'd9, 32'd9, 1'b1, 5'd3, 1'b1, 64'd81, 1'b1);
    wait_idle();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
